// File: rtl/trig_info_pkg.sv
// Field layout of the 128-bit TTC trigger-information word, beat-0 layout and
// unpacker state encoding, shared by the trigger-info unpacker files.
package trig_info_pkg;

   localparam int unsigned WORD_W       = 128;
   localparam int unsigned BEAT_W       = 64;

   localparam int unsigned TS_LSB       = 0;
   localparam int unsigned TS_W         = 44;
   localparam int unsigned TRIG_NUM_LSB = 44;
   localparam int unsigned TRIG_NUM_W   = 24;
   localparam int unsigned EVT_CNT_LSB  = 68;
   localparam int unsigned EVT_CNT_W    = 24;
   localparam int unsigned TYPE_LSB     = 92;
   localparam int unsigned TYPE_W       = 5;
   localparam int unsigned EMPTY_BIT    = 97;
   localparam int unsigned RSVD_LSB     = 98;
   localparam int unsigned RSVD_W       = 30;

   // Only the non-reserved part of an accepted word needs to be held.
   localparam int unsigned KEEP_W       = RSVD_LSB;

   localparam int unsigned B0_EVT_CNT_LSB  = 0;
   localparam int unsigned B0_TRIG_NUM_LSB = 24;
   localparam int unsigned B0_PAD_LSB      = 48;
   localparam int unsigned B0_PAD_W        = 10;
   localparam int unsigned B0_TYPE_LSB     = 58;
   localparam int unsigned B0_EMPTY_BIT    = 63;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_BEAT0 = 3'b010,
      ST_BEAT1 = 3'b100
   } unpack_state_t;

   typedef logic [KEEP_W-1:0] trig_word_t;

   function automatic logic [BEAT_W-1:0] pack_beat0(input trig_word_t w);
      logic [BEAT_W-1:0] b;
      b                                    = '0;
      b[B0_EVT_CNT_LSB  +: EVT_CNT_W]      = w[EVT_CNT_LSB  +: EVT_CNT_W];
      b[B0_TRIG_NUM_LSB +: TRIG_NUM_W]     = w[TRIG_NUM_LSB +: TRIG_NUM_W];
      b[B0_TYPE_LSB     +: TYPE_W]         = w[TYPE_LSB     +: TYPE_W];
      b[B0_EMPTY_BIT]                      = w[EMPTY_BIT];
      return b;
   endfunction

   function automatic logic [BEAT_W-1:0] pack_beat1(input trig_word_t w);
      logic [BEAT_W-1:0] b;
      b          = '0;
      b[TS_W-1:0] = w[TS_LSB +: TS_W];
      return b;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/ttc_trigger_info_unpacker.sv
// Drains 128-bit TTC trigger words, checks format and trigger-number sequence,
// and re-emits each event as two 64-bit beats. Option: TRIG_INFO_PASS_EMPTY_EN.
module ttc_trigger_info_unpacker
   import trig_info_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_trig_num,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [127:0]      s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [63:0]       m_data,
   output logic              m_last,
   output logic              seq_error,
   output logic [CNT_W-1:0]  seq_error_count,
   output logic [CNT_W-1:0]  format_error_count,
   output logic [CNT_W-1:0]  empty_event_count,
   output logic [CNT_W-1:0]  event_count
);

`ifdef TRIG_INFO_PASS_EMPTY_EN
   localparam bit PASS_EMPTY = 1'b1;
`else
   localparam bit PASS_EMPTY = 1'b0;
`endif

   unpack_state_t           state_q, state_d;
   trig_word_t              word_q;
   logic [TRIG_NUM_W-1:0]   expected_q;
   logic                    seq_error_q;

   logic                    load;
   logic                    fmt_inc, seq_inc, empty_inc, evt_inc;
   logic                    rsvd_nz;
   logic                    in_empty;
   logic [TRIG_NUM_W-1:0]   in_num;

   assign rsvd_nz  = |s_data[RSVD_LSB +: RSVD_W];
   assign in_empty = s_data[EMPTY_BIT];
   assign in_num   = s_data[TRIG_NUM_LSB +: TRIG_NUM_W];

   always_comb begin
      state_d   = state_q;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      m_data    = '0;
      load      = 1'b0;
      fmt_inc   = 1'b0;
      seq_inc   = 1'b0;
      empty_inc = 1'b0;
      evt_inc   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            s_ready = !reset;
            if (s_valid && !reset) begin
               if (rsvd_nz) begin
                  fmt_inc = 1'b1;
               end else begin
                  load      = 1'b1;
                  // A trigger-number reset in the same cycle overrides the check.
                  seq_inc   = !reset_trig_num && (in_num != expected_q);
                  empty_inc = in_empty;
                  if (PASS_EMPTY || !in_empty)
                     state_d = ST_BEAT0;
               end
            end
         end
         ST_BEAT0: begin
            m_valid = 1'b1;
            m_data  = pack_beat0(word_q);
            if (m_ready)
               state_d = ST_BEAT1;
         end
         ST_BEAT1: begin
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = pack_beat1(word_q);
            if (m_ready) begin
               evt_inc = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         word_q      <= '0;
         expected_q  <= TRIG_NUM_W'(1);
         seq_error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load)
            word_q <= s_data[KEEP_W-1:0];
         if (seq_inc)
            seq_error_q <= 1'b1;
         // Resync on every good word; 24-bit add wraps FFFFFF -> 0.
         if (reset_trig_num)
            expected_q <= TRIG_NUM_W'(1);
         else if (load)
            expected_q <= in_num + 1'b1;
      end
   end

   assign seq_error = seq_error_q;

   sat_counter #(.CNT_W(CNT_W)) u_seq_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (seq_inc),
      .count (seq_error_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_fmt_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (fmt_inc),
      .count (format_error_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_empty_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (empty_inc),
      .count (empty_event_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_evt_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (evt_inc),
      .count (event_count)
   );

endmodule
